// File: rtl/parity_serial_rx.sv
// Serial frame receiver: start bit, DATA_W data bits (LSB first), XOR parity bit and stop bit.
// It deserialises the frame into a word and flags parity and framing errors.
module parity_serial_rx #(
   parameter int DATA_W     = 8,
   parameter int BIT_CYC    = 4,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_in,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              parity_err,
   output logic              frame_err,
   output logic              busy
);

   localparam int CNT_W = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;
   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BIT_CYC/2 - 1);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BIT_CYC - 1);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   logic              rx_sync_p0;
   logic              rx_sync_p1;
   logic              rx_s;
   logic [2:0]        state;
   logic [CNT_W-1:0]  cyc_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] shift_reg;
   logic              par_acc;
   logic              perr_lat;
   logic              tick;

   // Stage p0/p1: two-flop synchroniser, idles high so reset looks like an idle line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_sync_p0 <= 1'b1;
         rx_sync_p1 <= 1'b1;
      end else begin
         rx_sync_p0 <= rx_in;
         rx_sync_p1 <= rx_sync_p0;
      end
   end

   assign rx_s = rx_sync_p1;
   assign tick = (state != IDLE) && (cyc_cnt == '0);
   assign busy = (state != IDLE);

   // Bit-timing FSM: every counter expiry lands on the middle of a serial bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cyc_cnt    <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         par_acc    <= 1'b0;
         perr_lat   <= 1'b0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (state == IDLE) begin
            if (!rx_s) begin
               state   <= START;
               cyc_cnt <= HALF_LOAD;
            end
         end else if (!tick) begin
            cyc_cnt <= cyc_cnt - CNT_W'(1);
         end else begin
            cyc_cnt <= FULL_LOAD;
            case (state)
               START: begin
                  if (rx_s) begin
                     state <= IDLE;
                  end else begin
                     state   <= DATA;
                     bit_cnt <= '0;
                     par_acc <= 1'b0;
                  end
               end
               DATA: begin
                  shift_reg[bit_cnt] <= rx_s;
                  par_acc            <= par_acc ^ rx_s;
                  if (bit_cnt == LAST_BIT) begin
                     state <= PARITY;
                  end else begin
                     bit_cnt <= bit_cnt + BIT_W'(1);
                  end
               end
               PARITY: begin
                  perr_lat <= ((par_acc ^ rx_s) != PARITY_ODD);
                  state    <= STOP;
               end
               STOP: begin
                  // Back to IDLE at the stop midpoint so a following start bit is not missed
                  state      <= IDLE;
                  rx_valid   <= 1'b1;
                  rx_data    <= shift_reg;
                  parity_err <= perr_lat;
                  frame_err  <= ~rx_s;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_parity_serial_rx.sv
// Directed bench for parity_serial_rx: default configuration plus an odd-parity instance.
module tb_parity_serial_rx;

   localparam int BC = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       line;
   logic       odd_sel;
   logic       rx_in;
   logic       rx_in_odd;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       parity_err;
   logic       frame_err;
   logic       busy;
   logic [7:0] odd_rx_data;
   logic       odd_rx_valid;
   logic       odd_parity_err;
   logic       odd_frame_err;
   logic       odd_busy;

   int pass_cnt = 0;
   int check_cnt = 0;
   int cyc = 0;
   int vcount = 0;
   int ovcount = 0;
   int busy_cnt = 0;
   logic [7:0] log_data [0:63];
   int         log_time [0:63];
   logic       log_perr [0:63];
   logic       log_ferr [0:63];
   logic [7:0] o_data;
   logic       o_perr;
   logic       o_ferr;

   assign rx_in     = odd_sel ? 1'b1 : line;
   assign rx_in_odd = odd_sel ? line : 1'b1;

   parity_serial_rx #(.DATA_W(8), .BIT_CYC(BC), .PARITY_ODD(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .rx_data(rx_data), .rx_valid(rx_valid),
      .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
   );

   parity_serial_rx #(.DATA_W(8), .BIT_CYC(BC), .PARITY_ODD(1'b1)) dut_odd (
      .clk(clk), .rst_n(rst_n), .rx_in(rx_in_odd), .rx_data(odd_rx_data), .rx_valid(odd_rx_valid),
      .parity_err(odd_parity_err), .frame_err(odd_frame_err), .busy(odd_busy)
   );

   always #5 clk = ~clk;

   // Cycle counter and pulse log, sampled just after each rising edge
   always @(posedge clk) begin
      #1;
      cyc = cyc + 1;
      if (busy) busy_cnt = busy_cnt + 1;
      if (rx_valid && vcount < 64) begin
         log_data[vcount] = rx_data;
         log_time[vcount] = cyc;
         log_perr[vcount] = parity_err;
         log_ferr[vcount] = frame_err;
         vcount = vcount + 1;
      end
      if (odd_rx_valid) begin
         ovcount = ovcount + 1;
         o_data  = odd_rx_data;
         o_perr  = odd_parity_err;
         o_ferr  = odd_frame_err;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d expected below 2000", cyc);
      $fatal(1);
   end

   task automatic drive_bit(input logic b);
      line = b;
      repeat (BC) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(par);
      drive_bit(stp);
      line = 1'b1;
   endtask

   task automatic wait_pulses(input int target);
      for (int i = 0; i < 80 && vcount < target; i++) @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      line = 1'b1;
      odd_sel = 1'b0;
      repeat (3) @(negedge clk);
      check_cnt++;
      if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h expected 00", rx_data); else pass_cnt++;
      check_cnt++;
      if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); else pass_cnt++;
      check_cnt++;
      if ({parity_err, frame_err} !== 2'b00) $display("FAIL reset_errs: got %b expected 00", {parity_err, frame_err}); else pass_cnt++;
      check_cnt++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_good_frame;
      int base;
      int t0;
      base = vcount;
      t0 = cyc;
      send_frame(8'hA5, 1'b0, 1'b1);
      wait_pulses(base + 1);
      repeat (10) @(negedge clk);
      check_cnt++;
      if (vcount - base !== 1) $display("FAIL good_pulses: got %0d expected 1", vcount - base); else pass_cnt++;
      check_cnt++;
      if (log_time[base] - t0 !== 45) $display("FAIL good_latency: got %0d expected 45", log_time[base] - t0); else pass_cnt++;
      check_cnt++;
      if (log_data[base] !== 8'hA5) $display("FAIL good_data: got %h expected a5", log_data[base]); else pass_cnt++;
      check_cnt++;
      if ({log_perr[base], log_ferr[base]} !== 2'b00) $display("FAIL good_errs: got %b expected 00", {log_perr[base], log_ferr[base]}); else pass_cnt++;
      check_cnt++;
      if (rx_data !== 8'hA5) $display("FAIL good_hold: got %h expected a5", rx_data); else pass_cnt++;
   endtask

   task automatic test_parity;
      int base;
      int obase;
      base = vcount;
      send_frame(8'h01, 1'b0, 1'b1);
      wait_pulses(base + 1);
      repeat (5) @(negedge clk);
      check_cnt++;
      if (vcount - base !== 1) $display("FAIL par_even_pulses: got %0d expected 1", vcount - base); else pass_cnt++;
      check_cnt++;
      if (log_data[base] !== 8'h01) $display("FAIL par_even_data: got %h expected 01", log_data[base]); else pass_cnt++;
      check_cnt++;
      if ({log_perr[base], log_ferr[base]} !== 2'b10) $display("FAIL par_even_errs: got %b expected 10", {log_perr[base], log_ferr[base]}); else pass_cnt++;

      odd_sel = 1'b1;
      obase = ovcount;
      send_frame(8'h01, 1'b0, 1'b1);
      for (int i = 0; i < 80 && ovcount == obase; i++) @(negedge clk);
      repeat (5) @(negedge clk);
      odd_sel = 1'b0;
      check_cnt++;
      if (ovcount - obase !== 1) $display("FAIL par_odd_pulses: got %0d expected 1", ovcount - obase); else pass_cnt++;
      check_cnt++;
      if (o_data !== 8'h01) $display("FAIL par_odd_data: got %h expected 01", o_data); else pass_cnt++;
      check_cnt++;
      if ({o_perr, o_ferr, odd_busy} !== 3'b000) $display("FAIL par_odd_errs: got %b expected 000", {o_perr, o_ferr, odd_busy}); else pass_cnt++;
   endtask

   task automatic test_frame_err;
      int base;
      base = vcount;
      send_frame(8'h3C, 1'b0, 1'b0);
      repeat (60) @(negedge clk);
      check_cnt++;
      if (vcount - base !== 1) $display("FAIL ferr_pulses: got %0d expected 1", vcount - base); else pass_cnt++;
      check_cnt++;
      if (log_data[base] !== 8'h3C) $display("FAIL ferr_data: got %h expected 3c", log_data[base]); else pass_cnt++;
      check_cnt++;
      if ({log_perr[base], log_ferr[base]} !== 2'b01) $display("FAIL ferr_errs: got %b expected 01", {log_perr[base], log_ferr[base]}); else pass_cnt++;
      check_cnt++;
      if ({busy, frame_err} !== 2'b01) $display("FAIL ferr_after: got busy,frame_err=%b expected 01", {busy, frame_err}); else pass_cnt++;
   endtask

   task automatic test_glitch;
      int base;
      int b0;
      base = vcount;
      b0 = busy_cnt;
      line = 1'b0;
      @(negedge clk);
      line = 1'b1;
      repeat (12) @(negedge clk);
      check_cnt++;
      if (busy_cnt - b0 !== 2) $display("FAIL glitch_busy: got %0d busy cycles expected 2", busy_cnt - b0); else pass_cnt++;
      check_cnt++;
      if (vcount - base !== 0) $display("FAIL glitch_pulses: got %0d expected 0", vcount - base); else pass_cnt++;
      check_cnt++;
      if (rx_data !== 8'h3C) $display("FAIL glitch_data: got %h expected 3c", rx_data); else pass_cnt++;
      check_cnt++;
      if ({parity_err, frame_err} !== 2'b01) $display("FAIL glitch_errs: got %b expected 01", {parity_err, frame_err}); else pass_cnt++;
   endtask

   task automatic test_back_to_back;
      int base;
      int t0;
      base = vcount;
      t0 = cyc;
      send_frame(8'h55, 1'b0, 1'b1);
      send_frame(8'hFF, 1'b0, 1'b1);
      wait_pulses(base + 2);
      repeat (10) @(negedge clk);
      check_cnt++;
      if (vcount - base !== 2) $display("FAIL b2b_pulses: got %0d expected 2", vcount - base); else pass_cnt++;
      check_cnt++;
      if (log_time[base] - t0 !== 45) $display("FAIL b2b_first_latency: got %0d expected 45", log_time[base] - t0); else pass_cnt++;
      check_cnt++;
      if (log_time[base+1] - log_time[base] !== 44) $display("FAIL b2b_spacing: got %0d expected 44", log_time[base+1] - log_time[base]); else pass_cnt++;
      check_cnt++;
      if (log_data[base] !== 8'h55) $display("FAIL b2b_data0: got %h expected 55", log_data[base]); else pass_cnt++;
      check_cnt++;
      if (log_data[base+1] !== 8'hFF) $display("FAIL b2b_data1: got %h expected ff", log_data[base+1]); else pass_cnt++;
      check_cnt++;
      if ({log_perr[base], log_ferr[base], log_perr[base+1], log_ferr[base+1]} !== 4'b0000)
         $display("FAIL b2b_errs: got %b expected 0000", {log_perr[base], log_ferr[base], log_perr[base+1], log_ferr[base+1]});
      else pass_cnt++;
   endtask

   task automatic test_reset_midframe;
      int base;
      base = vcount;
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      line = 1'b0;
      repeat (2) @(negedge clk);
      check_cnt++;
      if (busy !== 1'b1) $display("FAIL mid_busy: got %b expected 1", busy); else pass_cnt++;
      rst_n = 1'b0;
      #1;
      check_cnt++;
      if (rx_data !== 8'h00) $display("FAIL mid_rst_data: got %h expected 00", rx_data); else pass_cnt++;
      check_cnt++;
      if ({rx_valid, parity_err, frame_err, busy} !== 4'b0000)
         $display("FAIL mid_rst_ctrl: got %b expected 0000", {rx_valid, parity_err, frame_err, busy});
      else pass_cnt++;
      line = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      send_frame(8'h81, 1'b0, 1'b1);
      wait_pulses(base + 1);
      repeat (10) @(negedge clk);
      check_cnt++;
      if (vcount - base !== 1) $display("FAIL mid_pulses: got %0d expected 1", vcount - base); else pass_cnt++;
      check_cnt++;
      if (log_data[base] !== 8'h81) $display("FAIL mid_data: got %h expected 81", log_data[base]); else pass_cnt++;
      check_cnt++;
      if ({log_perr[base], log_ferr[base]} !== 2'b00) $display("FAIL mid_errs: got %b expected 00", {log_perr[base], log_ferr[base]}); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_parity();
      test_frame_err();
      test_glitch();
      test_back_to_back();
      test_reset_midframe();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
